// File: rtl/noc_arb_pkg.sv
// Shared flit encodings and field types
// for the NoC output-channel arbiter.
package noc_arb_pkg;

  localparam int FLIT_W = 3;
  localparam int LEN_WIDTH = 12;

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic [LEN_WIDTH-1:0] len_t;

  localparam flit_t FLIT_HEAD = 3'b001;
  localparam flit_t FLIT_BODY = 3'b010;
  localparam flit_t FLIT_TAIL = 3'b100;

endpackage

// File: rtl/arb_port_timer.sv
// Per-port packet-length timer: limit latched
// from header flits, count runs while holding.
module arb_port_timer
  import noc_arb_pkg::*;
#(
  parameter int LEN_W     = 12,
  parameter int FLIT_ID_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_ID_W-1:0] flit_id,
  input  logic [LEN_W-1:0]     length,
  input  logic                 run,
  output logic                 timesup
);

  logic [LEN_W-1:0] limit;
  logic [LEN_W-1:0] count;
  logic             is_head;

  assign is_head = (flit_id == FLIT_ID_W'(FLIT_HEAD));

  always_ff @(posedge clk) begin
    if (!rst) begin
      limit <= '0;
      count <= '0;
    end else begin
      if (is_head) limit <= length;
      if (!run) count <= '0;
      else if (!(&count)) count <= count + 1'b1;
    end
  end

  // A zero limit disables the timeout.
  assign timesup = (limit != '0) && (count == limit);

endmodule

// File: rtl/rr_timeout_arbiter.sv
// Round-robin output-channel arbiter with
// per-port length timeout and tail release.
module rr_timeout_arbiter
  import noc_arb_pkg::*;
#(
  parameter int N_PORTS      = 5,
  parameter int LEN_W        = 12,
  parameter int FLIT_ID_W    = 3,
  parameter int TAIL_RELEASE = 1,
  localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_PORTS-1:0]             req_i,
  input  logic [N_PORTS*FLIT_ID_W-1:0]   flit_id_i,
  input  logic [N_PORTS*LEN_W-1:0]       length_i,
  output logic [N_PORTS-1:0]             grant_o,
  output logic [IW-1:0]                  grant_idx_o,
  output logic                           grant_valid_o,
  output logic [N_PORTS:0]               state_o,
  output logic [N_PORTS-1:0]             timeout_o
);

  logic [N_PORTS-1:0] grant;
  logic [N_PORTS-1:0] grant_nxt;
  logic [N_PORTS-1:0] timesup;
  logic [N_PORTS-1:0] tail_rel;
  logic [N_PORTS-1:0] run;
  logic [N_PORTS-1:0] tmo;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      ptr_nxt;
  logic [IW-1:0]      cur_idx;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    logic [FLIT_ID_W-1:0] fid;
    assign fid = flit_id_i[p*FLIT_ID_W +: FLIT_ID_W];
    assign tail_rel[p] = (TAIL_RELEASE != 0) &&
      (fid == FLIT_ID_W'(FLIT_TAIL));
    assign run[p] = grant[p] & req_i[p] &
      ~timesup[p] & ~tail_rel[p];

    arb_port_timer #(
      .LEN_W     (LEN_W),
      .FLIT_ID_W (FLIT_ID_W)
    ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .flit_id (fid),
      .length  (length_i[p*LEN_W +: LEN_W]),
      .run     (run[p]),
      .timesup (timesup[p])
    );
  end

  // First requester after base, wrapping; base itself is checked last.
  function automatic logic [N_PORTS-1:0] pick(
    input logic [N_PORTS-1:0] r,
    input logic [IW-1:0]      base
  );
    logic [N_PORTS-1:0] g;
    logic               found;
    int                 j;
    g     = '0;
    found = 1'b0;
    for (int i = 1; i <= N_PORTS; i++) begin
      j = (int'(base) + i) % N_PORTS;
      if (!found && r[j]) begin
        g[j]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [IW-1:0] enc(
    input logic [N_PORTS-1:0] v
  );
    logic [IW-1:0] e;
    e = '0;
    for (int i = 0; i < N_PORTS; i++)
      if (v[i]) e = IW'(i);
    return e;
  endfunction

  assign cur_idx = enc(grant);
  assign tmo     = grant & req_i & timesup;

  always_comb begin
    grant_nxt = grant;
    ptr_nxt   = ptr;
    unique case (1'b1)
      (grant == '0): begin
        grant_nxt = pick(req_i, ptr);
      end
      (|run): begin
        grant_nxt = grant;
      end
      default: begin
        // Releasing port is masked so it cannot re-win at once.
        grant_nxt = pick(req_i & ~grant, cur_idx);
        ptr_nxt   = cur_idx;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant     <= '0;
      ptr       <= IW'(N_PORTS - 1);
      timeout_o <= '0;
    end else begin
      grant     <= grant_nxt;
      ptr       <= ptr_nxt;
      timeout_o <= tmo;
    end
  end

  assign grant_o       = grant;
  assign grant_idx_o   = cur_idx;
  assign grant_valid_o = |grant;
  assign state_o       = {grant, ~(|grant)};

endmodule

// File: tb/tb_rr_timeout_arbiter.sv
// Self-checking bench: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_rr_timeout_arbiter;

  localparam int N  = 5;
  localparam int LW = 12;
  localparam int FW = 3;
  localparam logic [2:0] HEAD = 3'b001;
  localparam logic [2:0] BODY = 3'b010;
  localparam logic [2:0] TAIL = 3'b100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*FW-1:0] flit = '0;
  logic [N*LW-1:0] len = '0;
  logic [N-1:0]  grant;
  logic [2:0]    gidx;
  logic          gvalid;
  logic [N:0]    state;
  logic [N-1:0]  tmo;

  int total = 0;
  int bad   = 0;

  // Model state: granted port (-1 idle), pointer, timers.
  int mg;
  int mptr;
  int mcnt[N];
  int mlim[N];
  logic [N-1:0] mtmo;

  rr_timeout_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req),
    .flit_id_i     (flit),
    .length_i      (len),
    .grant_o       (grant),
    .grant_idx_o   (gidx),
    .grant_valid_o (gvalid),
    .state_o       (state),
    .timeout_o     (tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d", total);
    $fatal(1);
  end

  function automatic logic [2:0] fl(int p);
    return flit[p*FW +: FW];
  endfunction

  function automatic int first_from(
    logic [N-1:0] r, int base, int excl);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (base + k) % N;
      if (j != excl && r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [N-1:0] nt;
    int ng;
    bit keep;
    bit ts;
    if (!rst) begin
      mg = -1;
      mptr = N - 1;
      mtmo = '0;
      for (int p = 0; p < N; p++) begin
        mcnt[p] = 0;
        mlim[p] = 0;
      end
      return;
    end
    nt = '0;
    keep = 0;
    ng = mg;
    if (mg < 0) begin
      ng = first_from(req, mptr, -1);
    end else begin
      ts = (mlim[mg] != 0) && (mcnt[mg] == mlim[mg]);
      if (req[mg] && ts) nt[mg] = 1'b1;
      keep = req[mg] && !ts && (fl(mg) != TAIL);
      if (!keep) begin
        ng = first_from(req, mg, mg);
        mptr = mg;
      end
    end
    for (int p = 0; p < N; p++) begin
      if (p == mg && keep)
        mcnt[p] = (mcnt[p] >= 4095) ? 4095 : mcnt[p] + 1;
      else
        mcnt[p] = 0;
      if (fl(p) == HEAD) mlim[p] = int'(len[p*LW +: LW]);
    end
    mg = ng;
    mtmo = nt;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flit(int p, logic [2:0] v);
    flit[p*FW +: FW] = v;
  endtask

  task automatic set_len(int p, int v);
    len[p*LW +: LW] = LW'(v);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    flit = '0;
    len = '0;
    cycle();
    cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (grant !== 5'b0) begin
        bad++;
        $display("FAIL reset_grant got=%b want=0", grant);
      end
      total++;
      if (state !== 6'b000001) begin
        bad++;
        $display("FAIL reset_state got=%b want=000001", state);
      end
      total++;
      if (gvalid !== 1'b0 || gidx !== 3'd0 || tmo !== 5'b0) begin
        bad++;
        $display("FAIL reset_misc valid=%b idx=%0d tmo=%b want 0",
          gvalid, gidx, tmo);
      end
      cycle();
    end
  endtask

  task automatic test_single_timeout();
    logic [N-1:0] eg;
    logic [N-1:0] et;
    do_reset();
    req = 5'b00001;
    set_flit(0, HEAD);
    set_len(0, 4);
    for (int k = 1; k <= 7; k++) begin
      cycle();
      if (k == 1) set_flit(0, BODY);
      eg = (k == 6) ? 5'b00000 : 5'b00001;
      et = (k == 6) ? 5'b00001 : 5'b00000;
      total++;
      if (grant !== eg || tmo !== et) begin
        bad++;
        $display("FAIL single_k%0d grant=%b tmo=%b want %b %b",
          k, grant, tmo, eg, et);
      end
    end
    req = '0;
    cycle();
    cycle();
  endtask

  task automatic test_round_robin();
    int cur;
    int nx;
    do_reset();
    req = '1;
    repeat (10) begin
      cycle();
      total++;
      if (grant !== 5'b00001 || tmo !== 5'b0) begin
        bad++;
        $display("FAIL rr_hold grant=%b tmo=%b want 00001 0",
          grant, tmo);
      end
    end
    cur = 0;
    for (int s = 0; s < 5; s++) begin
      req = ~(5'b00001 << cur);
      cycle();
      nx = (cur + 1) % N;
      total++;
      if (grant !== (5'b00001 << nx) || gidx !== 3'(nx)) begin
        bad++;
        $display("FAIL rr_step%0d grant=%b idx=%0d want port %0d",
          s, grant, gidx, nx);
      end
      cur = nx;
    end
    req = '0;
    cycle();
    cycle();
  endtask

  task automatic test_alternate();
    logic [N-1:0] eg[7];
    logic [N-1:0] et[7];
    eg = '{5'b01000, 5'b01000, 5'b01000, 5'b00010,
           5'b00010, 5'b00010, 5'b01000};
    et = '{5'b0, 5'b0, 5'b0, 5'b01000, 5'b0, 5'b0, 5'b00010};
    do_reset();
    req = 5'b00010;
    cycle();
    req = '0;
    cycle();
    total++;
    if (grant !== 5'b0) begin
      bad++;
      $display("FAIL alt_setup grant=%b want 0", grant);
    end
    req = 5'b01010;
    set_flit(1, HEAD);
    set_flit(3, HEAD);
    set_len(1, 2);
    set_len(3, 2);
    for (int k = 0; k < 7; k++) begin
      cycle();
      if (k == 0) begin
        set_flit(1, BODY);
        set_flit(3, BODY);
      end
      total++;
      if (grant !== eg[k] || tmo !== et[k]) begin
        bad++;
        $display("FAIL alt_e%0d grant=%b tmo=%b want %b %b",
          k + 1, grant, tmo, eg[k], et[k]);
      end
    end
    req = '0;
    cycle();
    cycle();
  endtask

  task automatic test_tail();
    do_reset();
    req = 5'b01100;
    set_flit(2, HEAD);
    set_len(2, 100);
    for (int k = 1; k <= 3; k++) begin
      cycle();
      set_flit(2, BODY);
      total++;
      if (grant !== 5'b00100) begin
        bad++;
        $display("FAIL tail_hold%0d grant=%b want 00100", k, grant);
      end
    end
    set_flit(2, TAIL);
    cycle();
    set_flit(2, BODY);
    total++;
    if (grant !== 5'b01000 || gidx !== 3'd3 || tmo !== 5'b0) begin
      bad++;
      $display("FAIL tail_move grant=%b idx=%0d tmo=%b want 01000 3 0",
        grant, gidx, tmo);
    end
    req = '0;
    cycle();
    cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 5'b10000;
    set_flit(4, HEAD);
    set_len(4, 50);
    cycle();
    set_flit(4, BODY);
    cycle();
    cycle();
    total++;
    if (grant !== 5'b10000) begin
      bad++;
      $display("FAIL rmid_pre grant=%b want 10000", grant);
    end
    rst = 1'b0;
    cycle();
    total++;
    if (grant !== 5'b0 || state !== 6'b000001 || tmo !== 5'b0) begin
      bad++;
      $display("FAIL rmid_abort grant=%b state=%b tmo=%b want 0 1 0",
        grant, state, tmo);
    end
    rst = 1'b1;
    req = 5'b00001;
    cycle();
    total++;
    if (grant !== 5'b00001 || gidx !== 3'd0 || gvalid !== 1'b1) begin
      bad++;
      $display("FAIL rmid_after grant=%b idx=%0d valid=%b want 00001",
        grant, gidx, gvalid);
    end
    req = '0;
    cycle();
    cycle();
  endtask

  task automatic test_random();
    logic [N-1:0] eg;
    int fsel;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 79) != 0);
      for (int p = 0; p < N; p++) begin
        if ($urandom_range(0, 3) == 0) req[p] = ~req[p];
        fsel = $urandom_range(0, 7);
        case (fsel)
          0: set_flit(p, HEAD);
          1: set_flit(p, TAIL);
          2: set_flit(p, 3'b000);
          default: set_flit(p, BODY);
        endcase
        set_len(p, $urandom_range(0, 6));
      end
      cycle();
      eg = (mg < 0) ? 5'b0 : (5'b00001 << mg);
      total++;
      if (grant !== eg || tmo !== mtmo) begin
        bad++;
        $display("FAIL rnd_c%0d grant=%b tmo=%b want %b %b",
          c, grant, tmo, eg, mtmo);
      end
      total++;
      if (state !== {eg, ~(|eg)} || gvalid !== (|eg) ||
          gidx !== 3'((mg < 0) ? 0 : mg)) begin
        bad++;
        $display("FAIL rnd_dec_c%0d state=%b idx=%0d valid=%b want port %0d",
          c, state, gidx, gvalid, mg);
      end
      total++;
      if (!$onehot0(grant)) begin
        bad++;
        $display("FAIL rnd_onehot_c%0d grant=%b want onehot0", c, grant);
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_timeout();
    test_round_robin();
    test_alternate();
    test_tail();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
